// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between the pclk-domain master and the register-bank completer.
// The bus has no pready/pslverr: every transfer is zero-wait-state.
interface apb_reg_slave_if;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata
    );
endinterface

// File: rtl/apb_reg_slave.sv
// Zero-wait-state APB register bank: NUM_REGS RW control registers plus a STATUS
// register at index NUM_REGS. It tracks the SETUP/ACCESS handshake and counts
// protocol violations. An erroneous transfer never writes a register.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 8
) (
    input  logic                     pclk,
    input  logic                     presetn,
    apb_reg_slave_if.slave           apb,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_stb,
    output logic                     proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         lat_addr_q, lat_addr_d;
    logic                lat_write_q, lat_write_d;
    logic [31:0]         lat_wdata_q, lat_wdata_d;
    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] stb_q, stb_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                proto_err_q, proto_err_d;
    logic                dec_err_q, dec_err_d;
    logic [31:0]         prdata_q, prdata_d;

    logic                err_s;
    logic                commit_s;
    logic                latch_s;
    logic [29:0]         word_off_s;
    logic                hit_s;
    logic [3:0]          idx_s;
    logic [31:0]         rd_val_s;
    logic [31:0]         status_s;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Address decode of the live bus address and read-data mux.
    always_comb begin
        word_off_s = apb.paddr[31:2] - BASE_ADDR[31:2];
        hit_s      = (apb.paddr[1:0] == 2'b00) && (word_off_s <= 30'(NUM_REGS));
        idx_s      = word_off_s[3:0];
        status_s   = {22'd0, dec_err_q, proto_err_q, err_cnt_q};
        rd_val_s   = 32'd0;
        if (idx_s == 4'(NUM_REGS)) begin
            rd_val_s = status_s;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_s == 4'(i)) begin
                    rd_val_s = regs_q[i];
                end else begin
                    rd_val_s = rd_val_s;
                end
            end
        end
    end

    // Handshake FSM: next state, latch requests, commit and error events.
    always_comb begin
        state_d  = state_q;
        err_s    = 1'b0;
        commit_s = 1'b0;
        latch_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = ST_SETUP;
                    latch_s = 1'b1;
                end else if (apb.psel && apb.penable) begin
                    state_d = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (apb.psel && apb.penable) begin
                    if ((apb.paddr == lat_addr_q) && (apb.pwrite == lat_write_q) &&
                        (!apb.pwrite || (apb.pwdata == lat_wdata_q))) begin
                        state_d  = ST_ACCESS;
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        err_s   = 1'b1;
                    end
                end else if (apb.psel) begin
                    // Setup held for more than one cycle: flag it but follow the new values.
                    state_d = ST_SETUP;
                    err_s   = 1'b1;
                    latch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    err_s   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (apb.psel && !apb.penable) begin
                    state_d = ST_SETUP;
                    latch_s = 1'b1;
                end else if (apb.psel && apb.penable) begin
                    state_d = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: latches, register writes, STATUS updates, read data.
    always_comb begin
        lat_addr_d  = lat_addr_q;
        lat_write_d = lat_write_q;
        lat_wdata_d = lat_wdata_q;
        regs_d      = regs_q;
        stb_d       = '0;
        err_cnt_d   = err_cnt_q;
        proto_err_d = proto_err_q;
        dec_err_d   = dec_err_q;
        prdata_d    = 32'd0;

        if (latch_s) begin
            lat_addr_d  = apb.paddr;
            lat_write_d = apb.pwrite;
            lat_wdata_d = apb.pwdata;
            prdata_d    = (!apb.pwrite && hit_s) ? rd_val_s : 32'd0;
        end else begin
            prdata_d    = 32'd0;
        end

        if (err_s) begin
            err_cnt_d   = sat_inc8(err_cnt_q);
            proto_err_d = 1'b1;
        end else begin
            err_cnt_d   = err_cnt_q;
        end

        // A clear-write applied after the error update so that the clear wins.
        if (commit_s) begin
            if (!hit_s) begin
                dec_err_d = 1'b1;
            end else if (apb.pwrite && (idx_s == 4'(NUM_REGS))) begin
                if (apb.pwdata[8]) begin
                    err_cnt_d   = 8'd0;
                    proto_err_d = 1'b0;
                end else begin
                    proto_err_d = proto_err_d;
                end
                if (apb.pwdata[9]) begin
                    dec_err_d = 1'b0;
                end else begin
                    dec_err_d = dec_err_d;
                end
            end else if (apb.pwrite) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_s == 4'(i)) begin
                        regs_d[i] = apb.pwdata;
                        stb_d[i]  = 1'b1;
                    end else begin
                        regs_d[i] = regs_q[i];
                    end
                end
            end else begin
                dec_err_d = dec_err_d;
            end
        end else begin
            dec_err_d = dec_err_d;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            lat_addr_q  <= 32'd0;
            lat_write_q <= 1'b0;
            lat_wdata_q <= 32'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
            stb_q       <= '0;
            err_cnt_q   <= 8'd0;
            proto_err_q <= 1'b0;
            dec_err_q   <= 1'b0;
            prdata_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_write_q <= lat_write_d;
            lat_wdata_q <= lat_wdata_d;
            regs_q      <= regs_d;
            stb_q       <= stb_d;
            err_cnt_q   <= err_cnt_d;
            proto_err_q <= proto_err_d;
            dec_err_q   <= dec_err_d;
            prdata_q    <= prdata_d;
        end
    end

    // Flatten the register array onto the core-facing output bus.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[32*i +: 32] = regs_q[i];
        end
    end

    assign reg_wr_stb = stb_q;
    assign proto_err  = proto_err_q;
    assign apb.prdata = prdata_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave with BASE_ADDR=0, NUM_REGS=8.
module tb_apb_reg_slave;
    localparam int NR = 8;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_0020;

    logic            pclk;
    logic            presetn;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]   reg_wr_stb;
    logic            proto_err;

    apb_reg_slave_if bus ();

    apb_reg_slave #(.BASE_ADDR(32'h0000_0000), .NUM_REGS(NR)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .apb        (bus),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb),
        .proto_err  (proto_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: register contents and STATUS fields.
    logic [31:0] m_regs [NR];
    int          m_cnt;
    bit          m_proto;
    bit          m_dec;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, required finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'd0;
        m_cnt = 0; m_proto = 1'b0; m_dec = 1'b0;
    endfunction

    function automatic void model_err();
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        m_proto = 1'b1;
    endfunction

    function automatic bit addr_hit(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 <= NR);
    endfunction

    function automatic logic [31:0] model_status();
        return 32'(m_cnt) + (m_proto ? 32'h100 : 32'h0) + (m_dec ? 32'h200 : 32'h0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!addr_hit(a)) return 32'd0;
        if (a / 4 == NR) return model_status();
        return m_regs[a / 4];
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        if (!addr_hit(a)) begin
            m_dec = 1'b1;
        end else if (a / 4 == NR) begin
            if (d[8]) begin m_cnt = 0; m_proto = 1'b0; end
            if (d[9]) m_dec = 1'b0;
        end else begin
            m_regs[a / 4] = d;
        end
    endfunction

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    // One SETUP+ACCESS transfer; leaves the bus in ACCESS so another may follow directly.
    task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd);
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwrite = w; bus.pwdata = d;
        @(negedge pclk);
        bus.penable = 1'b1;
        rd = bus.prdata;
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        apb_xfer(a, 1'b1, d, rd);
        model_write(a, d);
    endtask

    task automatic check_read(input string name, input logic [31:0] a);
        logic [31:0] rd;
        logic [31:0] exp;
        exp = model_read(a);
        apb_xfer(a, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL %s: addr %h prdata %h required %h", name, a, rd, exp);
        end
    endtask

    task automatic check_regs(input string name);
        checks++;
        if (reg_q !== model_flat()) begin
            errors++;
            $display("FAIL %s: reg_q %h required %h", name, reg_q, model_flat());
        end
    endtask

    task automatic test_reset();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = 32'd0;
        bus.pwrite = 1'b0; bus.pwdata = 32'd0;
        presetn = 1'b0;
        model_reset();
        repeat (3) @(negedge pclk);
        checks++;
        if ({reg_q, reg_wr_stb, proto_err, bus.prdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: reg_q %h stb %b perr %b prdata %h required all 0",
                     reg_q, reg_wr_stb, proto_err, bus.prdata);
        end
        presetn = 1'b1;
        check_read("reset_status", STATUS_ADDR);
        bus_idle();
    endtask

    task automatic test_basic();
        do_write(32'h04, 32'hDEAD_BEEF);
        bus_idle();
        checks++;
        if (reg_wr_stb !== 8'b0000_0010) begin
            errors++;
            $display("FAIL wr_stb_pulse: got %b required %b", reg_wr_stb, 8'b0000_0010);
        end
        @(negedge pclk);
        checks++;
        if (reg_wr_stb !== 8'b0000_0000) begin
            errors++;
            $display("FAIL wr_stb_clear: got %b required %b", reg_wr_stb, 8'b0000_0000);
        end
        check_regs("basic_reg_q");
        check_read("basic_read", 32'h04);
        bus_idle();
        @(negedge pclk);
        checks++;
        if (bus.prdata !== 32'd0) begin
            errors++;
            $display("FAIL prdata_idle: got %h required 0", bus.prdata);
        end
    endtask

    task automatic test_back_to_back();
        do_write(32'h00, 32'd1);
        do_write(32'h08, 32'd3);
        check_read("b2b_read0", 32'h00);
        check_read("b2b_read2", 32'h08);
        check_read("b2b_status", STATUS_ADDR);
        bus_idle();
        check_regs("b2b_reg_q");
    endtask

    task automatic test_no_setup();
        bus_idle();
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 32'h00;
        bus.pwrite = 1'b1; bus.pwdata = 32'd5;
        model_err();
        bus_idle();
        check_regs("nosetup_reg0");
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL nosetup_proto_err: got %b required 1", proto_err);
        end
        bus_idle();
        check_read("nosetup_status", STATUS_ADDR);
        do_write(STATUS_ADDR, 32'h0000_0100);
        check_read("clear_status", STATUS_ADDR);
        bus_idle();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_proto_err: got %b required 0", proto_err);
        end
    endtask

    task automatic addr_change_err();
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h04;
        bus.pwrite = 1'b1; bus.pwdata = 32'h1234_5678;
        @(negedge pclk);
        bus.penable = 1'b1; bus.paddr = 32'h08;
        model_err();
    endtask

    task automatic test_addr_change();
        bus_idle();
        addr_change_err();
        bus_idle();
        check_regs("addrchg_nowrite");
        check_read("addrchg_status", STATUS_ADDR);
        bus_idle();
        for (int i = 0; i < 256; i++) addr_change_err();
        bus_idle();
        check_read("saturate_status", STATUS_ADDR);
        bus_idle();
        check_regs("saturate_regs");
        do_write(STATUS_ADDR, 32'h0000_0100);
        bus_idle();
    endtask

    task automatic test_decode_miss();
        do_write(32'h44, 32'hCAFE_F00D);
        bus_idle();
        check_regs("miss_write_regs");
        check_read("miss_write_status", STATUS_ADDR);
        check_read("miss_misaligned", 32'h02);
        check_read("miss_status_after", STATUS_ADDR);
        do_write(STATUS_ADDR, 32'h0000_0200);
        check_read("clear_dec_err", STATUS_ADDR);
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, NR)) * 32'd4;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d);
            end else begin
                check_read("rand_read", a);
            end
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();
        check_regs("rand_regs");
        check_read("rand_status", STATUS_ADDR);
        bus_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h00;
        bus.pwrite = 1'b1; bus.pwdata = 32'h0000_00FF;
        @(posedge pclk);
        #2 presetn = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({reg_q, bus.prdata} !== '0) begin
            errors++;
            $display("FAIL midreset_clear: reg_q %h prdata %h required 0", reg_q, bus.prdata);
        end
        @(negedge pclk);
        bus.penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b1;
        bus_idle();
        check_regs("midreset_nowrite");
        check_read("midreset_read0", 32'h00);
        bus_idle();
        // Stray penable at the first sampled edge after reset counts as an error.
        presetn = 1'b0;
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 32'h00;
        presetn = 1'b1;
        model_err();
        bus_idle();
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_penable: proto_err %b required 1", proto_err);
        end
        check_read("stray_status", STATUS_ADDR);
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_no_setup();
        test_addr_change();
        test_decode_miss();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
